// File: rtl/av_pkg.sv
// Shared definitions for the VM bytecode path: loader state encoding and
// the memory geometry also used by the CPU's bytecode RAM declaration.
package av_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    HDR2  = 3'd3,
    HDR3  = 3'd4,
    DATA  = 3'd5,
    WRITE = 3'd6,
    CSUM  = 3'd7
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         MEM_DEPTH_DEFAULT = 'h6F;

endpackage

// File: rtl/bytecode_loader.sv
// Streams framed bytecode images into the VM bytecode RAM, holding the CPU
// in reset while a frame is in flight and reporting sticky done/error.
module bytecode_loader
  import av_pkg::*;
#(
  parameter int         ADDR_W    = 16,
  parameter int         MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [15:0]       remaining;
  logic [7:0]        addr_hi;
  logic [7:0]        len_hi;
  logic [7:0]        sum;
  logic              range_err;

  logic       xfer;
  logic [7:0] sum_next;
  logic       in_range;

  assign xfer     = in_valid && in_ready;
  assign sum_next = sum + in_data;
  assign in_range = 32'(cur_addr) < DEPTH;

  // NOTE: every register here, outputs included, is assigned with <= inside
  // one clocked block so all state updates see the pre-edge values together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      addr_hi   <= '0;
      len_hi    <= '0;
      sum       <= '0;
      range_err <= 1'b0;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer && in_data == SYNC_BYTE) begin
            state     <= HDR0;
            done      <= 1'b0;
            error     <= 1'b0;
            sum       <= '0;
            range_err <= 1'b0;
            cpu_hold  <= 1'b1;
          end
        end
        HDR0: begin
          if (xfer) begin
            addr_hi <= in_data;
            sum     <= sum_next;
            state   <= HDR1;
          end
        end
        HDR1: begin
          if (xfer) begin
            cur_addr <= ADDR_W'({addr_hi, in_data});
            sum      <= sum_next;
            state    <= HDR2;
          end
        end
        HDR2: begin
          if (xfer) begin
            len_hi <= in_data;
            sum    <= sum_next;
            state  <= HDR3;
          end
        end
        HDR3: begin
          if (xfer) begin
            remaining <= {len_hi, in_data};
            sum       <= sum_next;
            state     <= ({len_hi, in_data} == 16'd0) ? CSUM : DATA;
          end
        end
        DATA: begin
          // Out-of-range bytes are consumed and summed but never strobed.
          if (xfer) begin
            mem_wdata <= in_data;
            mem_addr  <= cur_addr;
            mem_we    <= in_range;
            range_err <= range_err | ~in_range;
            sum       <= sum_next;
            in_ready  <= 1'b0;
            state     <= WRITE;
          end
        end
        WRITE: begin
          cur_addr  <= cur_addr + ADDR_W'(1);
          remaining <= remaining - 16'd1;
          in_ready  <= 1'b1;
          state     <= (remaining != 16'd1) ? DATA : CSUM;
        end
        CSUM: begin
          if (xfer) begin
            sum      <= sum_next;
            cpu_hold <= 1'b0;
            state    <= IDLE;
            if (sum_next == 8'h00 && !range_err) begin
              done <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bytecode_loader.sv
// Self-checking bench for bytecode_loader: table of directed frames, a reset
// mid-frame sequence and random frames compared against a frame-level model.
module tb_bytecode_loader;
  import av_pkg::*;

  localparam int MEM_DEPTH = 'h6F;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] len;
    logic [7:0]  adj;
    int          noise;
    bit          exp_done;
    int          exp_writes;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  bit  exp_done;
  int  exp_len;
  int  ready_low = 0;

  always #5 clk = ~clk;

  bytecode_loader dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always @(negedge clk) begin
    if (mem_we) got_q.push_back('{addr: mem_addr, data: mem_wdata});
    if (!in_ready) ready_low++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic byte_q_t make_frame(input logic [15:0] a, input logic [15:0] len,
                                         input byte_q_t pl, input logic [7:0] adj);
    byte_q_t    f;
    logic [7:0] s = 8'h00;
    f.push_back(SYNC_BYTE_DEFAULT);
    f.push_back(a[15:8]);
    f.push_back(a[7:0]);
    f.push_back(len[15:8]);
    f.push_back(len[7:0]);
    foreach (pl[i]) f.push_back(pl[i]);
    for (int i = 1; i < f.size(); i++) s = s + f[i];
    f.push_back(8'(8'h00 - s) + adj);
    return f;
  endfunction

  // Frame-level reference: which bytes land where, and whether the frame is good.
  task automatic model(input byte_q_t f);
    int          k = 0;
    int          sum = 0;
    int          a;
    bit          ok;
    while (f[k] != SYNC_BYTE_DEFAULT) k++;
    a       = {f[k+1], f[k+2]};
    exp_len = {f[k+3], f[k+4]};
    for (int i = k + 1; i < f.size(); i++) sum += f[i];
    ok = (sum % 256) == 0;
    exp_q.delete();
    for (int i = 0; i < exp_len; i++) begin
      int wa = (a + i) % 65536;
      if (wa < MEM_DEPTH) exp_q.push_back('{addr: 16'(wa), data: f[k + 5 + i]});
      else ok = 1'b0;
    end
    exp_done = ok;
  endtask

  // Called and returns at posedge+1; holds in_valid high unless a gap is asked.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit sent = 1'b0;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 20 && !sent; t++) begin
      @(negedge clk);
      if (in_ready) sent = 1'b1;
      @(posedge clk); #1;
    end
    if (!sent) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte %0h, required 1", b);
    end
  endtask

  task automatic run_frame(input string name, input byte_q_t f, input int max_gap);
    model(f);
    got_q.delete();
    ready_low = 0;
    foreach (f[i]) begin
      send_byte(f[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      if (i == f.size() - 2) check({name, "_hold_busy"}, 32'(cpu_hold), 32'd1);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({name, "_nwrites"}, got_q.size(), exp_q.size());
    if (got_q.size() == exp_q.size())
      foreach (exp_q[i]) check({name, "_write"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({name, "_done"}, 32'(done), 32'(exp_done));
    check({name, "_error"}, 32'(error), 32'(!exp_done));
    check({name, "_hold_idle"}, 32'(cpu_hold), 32'd0);
    check({name, "_ready_low"}, ready_low, exp_len);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t    vecs[6];
    byte_q_t noise_bytes;
    byte_q_t pl;
    byte_q_t f;

    noise_bytes = '{8'h00, 8'hFF, 8'hA4};
    vecs[0] = '{16'h0000, 16'd3, 8'h00, 0, 1'b1, 3};
    vecs[1] = '{16'h0000, 16'd3, 8'h01, 0, 1'b0, 3};
    vecs[2] = '{16'h006D, 16'd4, 8'h00, 0, 1'b0, 2};
    vecs[3] = '{16'h0010, 16'd0, 8'h00, 0, 1'b1, 0};
    vecs[4] = '{16'hFFFE, 16'd3, 8'h00, 0, 1'b0, 1};
    vecs[5] = '{16'h006C, 16'd3, 8'h00, 3, 1'b1, 3};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #3;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table; payload bytes are 12 34 56 78 ...
    foreach (vecs[v]) begin
      pl.delete();
      for (int i = 0; i < int'(vecs[v].len); i++) pl.push_back(8'(8'h12 + 8'h22 * i));
      f = make_frame(vecs[v].addr, vecs[v].len, pl, vecs[v].adj);
      for (int i = vecs[v].noise - 1; i >= 0; i--) f.push_front(noise_bytes[i]);
      if (v == 0) check("tbl_csum_byte", 32'(f[f.size()-1]), 32'h61);
      if (v == 3) check("tbl_zero_csum", 32'(f[f.size()-1]), 32'hF0);
      run_frame($sformatf("tbl%0d", v), f, 0);
      check($sformatf("tbl%0d_exp_done", v), 32'(done), 32'(vecs[v].exp_done));
      check($sformatf("tbl%0d_exp_writes", v), got_q.size(), vecs[v].exp_writes);
    end

    // Reset asserted while the 2nd payload byte is being written.
    f = make_frame(16'h0020, 16'd3, '{8'h11, 8'h22, 8'h33}, 8'h00);
    for (int i = 0; i < 7; i++) send_byte(f[i], 0);
    check("mid_we", 32'(mem_we), 32'd1);
    check("mid_ready", 32'(in_ready), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_hold", 32'(cpu_hold), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_frame("after_rst", make_frame(16'h0040, 16'd3, '{8'hDE, 8'hAD, 8'hBE}, 8'h00), 0);

    // Random frames with noise, stalls and occasional bad checksums.
    for (int r = 0; r < 30; r++) begin
      logic [15:0] a;
      logic [15:0] len;
      logic [7:0]  adj;
      a   = (r % 2 == 0) ? 16'($urandom_range(0, 'h7F)) : 16'($urandom);
      len = 16'($urandom_range(0, 6));
      adj = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      pl.delete();
      for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom));
      f = make_frame(a, len, pl, adj);
      for (int i = int'($urandom_range(0, 2)); i > 0; i--) begin
        logic [7:0] nb = 8'($urandom);
        if (nb == SYNC_BYTE_DEFAULT) nb = 8'h5A;
        f.push_front(nb);
      end
      run_frame($sformatf("rnd%0d", r), f, (r % 3 == 0) ? 0 : 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
